multi_timer: RTL and testbench

Parametrised multi-channel successor to the single-channel countdown timer. Holds `CH` independent countdown channels of `W` bits behind one shared command interface. Each channel has its own power-up sequence, one-shot or auto-reload mode, and optional pause. The front panel and controller address channels through `sel`, read back the selected channel on `out`, and watch per-channel `expire` pulses.

---
 rtl/multi_timer_if.sv | 13 +
 rtl/multi_timer.sv | 83 ++++++++
 tb/tb_multi_timer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/multi_timer_if.sv
// multi_timer_if: command, select and readback bundle shared by all multi_timer channels
interface multi_timer_if #(
  parameter int CH = 4,
  parameter int W = 8,
  parameter int SW = $clog2(CH)
);
  logic on, off, ok, pause, mode;
  logic [SW-1:0] sel;
  logic [W-1:0] value, out;
  logic [CH-1:0] expire, busy;
  modport master (output on, off, ok, pause, sel, mode, value, input out, expire, busy);
  modport slave (input on, off, ok, pause, sel, mode, value, output out, expire, busy);
endinterface

// File: rtl/multi_timer.sv
// multi_timer: CH independent W-bit countdown channels on one shared command port; MULTI_TIMER_PAUSE_EN adds RUN/HOLD pause
module multi_timer #(
  parameter int CH = 4,
  parameter int W = 8,
  parameter int SW = $clog2(CH)
) (
  input logic clk,
  input logic reset,
  multi_timer_if.slave bus
);
  typedef enum logic [2:0] {OFF, WAKE1, WAKE2, IDLE, LOAD, RUN, HOLD} state_t;
  logic [W-1:0] disp [CH];
  logic pause_cmd;
`ifdef MULTI_TIMER_PAUSE_EN
  assign pause_cmd = bus.pause;
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
  assign pause_cmd = 1'b0;
`endif
  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t st_q, st_d;
    logic [W-1:0] cnt_q, cnt_d, sv_q, sv_d;
    logic sm_q, sm_d, exp_q, exp_d, hit;
    assign hit = bus.sel == SW'(i);
    always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      sv_d = sv_q;
      sm_d = sm_q;
      exp_d = 1'b0;
      case (st_q)
        OFF: st_d = hit && bus.on ? WAKE1 : OFF;
        WAKE1: st_d = WAKE2;
        WAKE2: st_d = IDLE;
        IDLE: if (hit && bus.ok) begin
          st_d = LOAD;
          cnt_d = bus.value;
          sv_d = bus.value;
          sm_d = bus.mode;
        end
        LOAD: st_d = RUN;
        RUN: if (hit && pause_cmd) st_d = HOLD;
        else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          exp_d = 1'b1;
          cnt_d = sm_q ? sv_q : '0;
          st_d = sm_q ? RUN : OFF;
        end
`ifdef MULTI_TIMER_PAUSE_EN
        HOLD: st_d = hit && pause_cmd ? RUN : HOLD;
`endif
        default: ;
      endcase
      if (hit && bus.off && !(st_q inside {OFF, WAKE1})) begin
        st_d = OFF;
        cnt_d = '0;
        sv_d = '0;
        sm_d = 1'b0;
        exp_d = 1'b0;
      end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q <= OFF;
        cnt_q <= '0;
        sv_q <= '0;
        sm_q <= 1'b0;
        exp_q <= 1'b0;
      end else begin
        st_q <= st_d;
        cnt_q <= cnt_d;
        sv_q <= sv_d;
        sm_q <= sm_d;
        exp_q <= exp_d;
      end
    end
    assign disp[i] = st_q inside {IDLE, LOAD} ? '0 : st_q inside {RUN, HOLD} ? cnt_q : '1;
    assign bus.expire[i] = exp_q;
    assign bus.busy[i] = st_q inside {RUN, HOLD};
  end
  assign bus.out = int'(bus.sel) < CH ? disp[bus.sel] : '1;
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: scoreboard bench for multi_timer
module tb_multi_timer;
  localparam int CH = 5;
  localparam int W = 8;
  localparam int SW = 3;
  localparam logic [W-1:0] FF = '1;
  typedef struct {
    logic [W-1:0] out;
    logic [CH-1:0] expire;
    logic [CH-1:0] busy;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t sb [$];
  multi_timer_if #(.CH(CH), .W(W), .SW(SW)) bus ();
  multi_timer #(.CH(CH), .W(W), .SW(SW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int s, input logic o, input logic f, input logic a, input logic p, input logic m, input int v);
    bus.sel = SW'(s);
    bus.on = o;
    bus.off = f;
    bus.ok = a;
    bus.pause = p;
    bus.mode = m;
    bus.value = W'(v);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 8; s++) begin
      bus.sel = SW'(s);
      #1;
      checks++;
      if ({bus.out, bus.expire, bus.busy} !== {FF, {CH{1'b0}}, {CH{1'b0}}}) begin
        failures++;
        $display("FAIL reset sel=%0d out=%h expire=%b busy=%b expected out=%h expire=0 busy=0", s, bus.out, bus.expire, bus.busy, FF);
      end
    end
  endtask
  task automatic test_oneshot();
    exp_t e;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      drive(1, k == 0, 0, k == 3, 0, 0, 3);
      sb.push_back('{k < 2 ? FF : k < 4 ? W'(0) : k < 8 ? W'(7 - k) : FF,
                     k == 8 ? CH'(2) : CH'(0),
                     (k >= 4 && k < 8) ? CH'(2) : CH'(0)});
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.out, bus.expire, bus.busy} !== {e.out, e.expire, e.busy}) begin
        failures++;
        $display("FAIL oneshot k=%0d out=%h expire=%b busy=%b expected out=%h expire=%b busy=%b", k, bus.out, bus.expire, bus.busy, e.out, e.expire, e.busy);
      end
    end
    bus.sel = SW'(0);
    #1;
    checks++;
    if (bus.out !== FF) begin
      failures++;
      $display("FAIL oneshot_ch0 out=%h expected %h", bus.out, FF);
    end
  endtask
  task automatic test_two_channels();
    exp_t e;
    logic [CH-1:0] ex, bs;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      drive((k == 0 || k == 4) ? 0 : 2, k < 2, 0, k == 4 || k == 5, 0, k == 4, k == 4 ? 2 : 5);
      ex = '0;
      bs = '0;
      ex[0] = k >= 8 && (k - 8) % 3 == 0;
      ex[2] = k == 12;
      bs[0] = k >= 5;
      bs[2] = k >= 6 && k < 12;
      sb.push_back('{k < 3 ? FF : k < 6 ? W'(0) : k < 12 ? W'(11 - k) : FF, ex, bs});
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.out, bus.expire, bus.busy} !== {e.out, e.expire, e.busy}) begin
        failures++;
        $display("FAIL two_ch k=%0d out=%h expire=%b busy=%b expected out=%h expire=%b busy=%b", k, bus.out, bus.expire, bus.busy, e.out, e.expire, e.busy);
      end
    end
  endtask
  task automatic test_off_on();
    exp_t e;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      drive(k == 15 ? 5 : 3, k inside {0, 3, 4, 8, 12}, k inside {1, 3, 4, 7, 10}, k == 15, 0, 0, 9);
      sb.push_back('{k inside {2, 6, 14, 16, 17} ? W'(0) : FF, '0, '0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.out, bus.expire, bus.busy} !== {e.out, e.expire, e.busy}) begin
        failures++;
        $display("FAIL off_on k=%0d out=%h expire=%b busy=%b expected out=%h expire=%b busy=%b", k, bus.out, bus.expire, bus.busy, e.out, e.expire, e.busy);
      end
    end
  endtask
  task automatic test_reset_abort();
    exp_t e;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(0, k == 0, 0, k == 3, 0, 1, 2);
      reset = k == 12;
      if (k < 2) sb.push_back('{FF, '0, '0});
      else if (k < 4) sb.push_back('{W'(0), '0, '0});
      else if (k < 12) sb.push_back('{W'(2 - (k - 4) % 3), (k >= 7 && (k - 7) % 3 == 0) ? CH'(1) : CH'(0), CH'(1)});
      else sb.push_back('{FF, '0, '0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.out, bus.expire, bus.busy} !== {e.out, e.expire, e.busy}) begin
        failures++;
        $display("FAIL reset_abort k=%0d out=%h expire=%b busy=%b expected out=%h expire=%b busy=%b", k, bus.out, bus.expire, bus.busy, e.out, e.expire, e.busy);
      end
    end
    reset = 1'b0;
  endtask
  task automatic test_reload_zero();
    exp_t e;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(4, k == 0, k == 12, k == 3, 0, 1, 0);
      if (k < 2) sb.push_back('{FF, '0, '0});
      else if (k < 4) sb.push_back('{W'(0), '0, '0});
      else if (k < 12) sb.push_back('{W'(0), k >= 5 ? CH'(16) : CH'(0), CH'(16)});
      else sb.push_back('{FF, '0, '0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.out, bus.expire, bus.busy} !== {e.out, e.expire, e.busy}) begin
        failures++;
        $display("FAIL reload_zero k=%0d out=%h expire=%b busy=%b expected out=%h expire=%b busy=%b", k, bus.out, bus.expire, bus.busy, e.out, e.expire, e.busy);
      end
    end
  endtask
  task automatic test_pause();
    exp_t e;
    int t;
    do_reset();
    for (int k = 0; k < 22; k++) begin
      drive(1, k == 0, 0, k == 3, k == 9 || k == 12, 0, 10);
`ifdef MULTI_TIMER_PAUSE_EN
      t = k < 9 ? k : k <= 12 ? 8 : k - 4;
`else
      t = k;
`endif
      sb.push_back('{t < 2 ? FF : t < 4 ? W'(0) : t <= 14 ? W'(14 - t) : FF,
                     t == 15 ? CH'(2) : CH'(0),
                     (t >= 4 && t <= 14) ? CH'(2) : CH'(0)});
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.out, bus.expire, bus.busy} !== {e.out, e.expire, e.busy}) begin
        failures++;
        $display("FAIL pause k=%0d out=%h expire=%b busy=%b expected out=%h expire=%b busy=%b", k, bus.out, bus.expire, bus.busy, e.out, e.expire, e.busy);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_oneshot();
    test_two_channels();
    test_off_on();
    test_reset_abort();
    test_reload_zero();
    test_pause();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
